// File: rtl/add_arb_pkg.sv
// Shared helpers for the add_arbiter slice: id width, pointer reset value
// and flat-bus slice indexing.
package add_arb_pkg;

  // Smallest index width able to name every requester.
  function automatic int id_width(input int nreq);
    int w;
    w = 1;
    while ((1 << w) < nreq) begin
      w = w + 1;
    end
    return w;
  endfunction

  // Pointer value after reset: the last requester, so requester 0 wins first.
  function automatic int last_rst(input int nreq);
    return nreq - 1;
  endfunction

  // Low bit of requester idx inside a flat bus of w-bit lanes.
  function automatic int slice_lo(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/add.sv
// Plain unsigned W-bit adder (combinational); callers widen the operands
// when they need the carry.
module add #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/add_arbiter_rr_pick.sv
// Combinational cyclic-priority picker: first set req bit strictly after
// `last`, wrapping around, with `last` itself checked at the very end.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  win,
  output logic            any_gnt
);

  // Scan last+1 .. last+NREQ (mod NREQ) and take the first requester found.
  always_comb begin
    int idx;
    gnt     = '0;
    win     = '0;
    any_gnt = 1'b0;
    idx     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last) + k) % NREQ;
      if (!any_gnt && req[idx]) begin
        gnt[idx] = 1'b1;
        win      = IDW'(idx);
        any_gnt  = 1'b1;
      end else begin
        any_gnt  = any_gnt;
      end
    end
  end

endmodule

// File: rtl/add_arbiter.sv
// add_arbiter: round-robin sharing of one registered adder among NREQ
// requesters. Grant is combinational; the sum appears two edges later with
// the owner's index. Build option ADD_ARB_SAT_EN: saturate on carry-out
// instead of wrapping.
module add_arbiter
  import add_arb_pkg::*;
#(
  parameter int N    = 7,
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                  clk,
  input  logic                  init,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*(N+1)-1:0] lhs_flat,
  input  logic [NREQ*(N+1)-1:0] rhs_flat,
  output logic [NREQ-1:0]       gnt,
  output logic [N:0]            res,
  output logic                  res_valid,
  output logic [IDW-1:0]        res_id,
  output logic                  busy
);

  localparam int W = N + 1;
  localparam logic [IDW-1:0] LAST_RST = IDW'(last_rst(NREQ));

  logic [NREQ-1:0] pick_gnt_s;
  logic [IDW-1:0]  win_s;
  logic            any_gnt_s;
  logic [W-1:0]    lhs_sel_s;
  logic [W-1:0]    rhs_sel_s;
  logic [W-1:0]    res_nxt_s;

  logic [IDW-1:0]  last_r;
  logic [W-1:0]    s1_lhs_r;
  logic [W-1:0]    s1_rhs_r;
  logic [IDW-1:0]  s1_id_r;
  logic            s1_valid_r;
  logic [W-1:0]    res_r;
  logic [IDW-1:0]  res_id_r;
  logic            res_valid_r;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req     (req),
    .last    (last_r),
    .gnt     (pick_gnt_s),
    .win     (win_s),
    .any_gnt (any_gnt_s)
  );

  // No grant may escape while reset is held, even with requests pending.
  assign gnt = init ? '0 : pick_gnt_s;

  assign lhs_sel_s = lhs_flat[slice_lo(int'(win_s), W) +: W];
  assign rhs_sel_s = rhs_flat[slice_lo(int'(win_s), W) +: W];

`ifdef ADD_ARB_SAT_EN
  logic [W:0] sum_s;

  add #(.W(W + 1)) u_add (
    .a   ({1'b0, s1_lhs_r}),
    .b   ({1'b0, s1_rhs_r}),
    .sum (sum_s)
  );

  // Clamp to all ones when the sum carries out of W bits.
  always_comb begin
    res_nxt_s = sum_s[W-1:0];
    if (sum_s[W]) begin
      res_nxt_s = {W{1'b1}};
    end else begin
      res_nxt_s = sum_s[W-1:0];
    end
  end
`else
  logic [W-1:0] sum_s;

  add #(.W(W)) u_add (
    .a   (s1_lhs_r),
    .b   (s1_rhs_r),
    .sum (sum_s)
  );

  assign res_nxt_s = sum_s;
`endif

  // Pick stage capture and result stage register; reset drops in-flight work.
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      last_r      <= LAST_RST;
      s1_lhs_r    <= '0;
      s1_rhs_r    <= '0;
      s1_id_r     <= '0;
      s1_valid_r  <= 1'b0;
      res_r       <= '0;
      res_id_r    <= '0;
      res_valid_r <= 1'b0;
    end else begin
      if (any_gnt_s) begin
        s1_lhs_r   <= lhs_sel_s;
        s1_rhs_r   <= rhs_sel_s;
        s1_id_r    <= win_s;
        s1_valid_r <= 1'b1;
        last_r     <= win_s;
      end else begin
        s1_valid_r <= 1'b0;
      end
      res_r       <= res_nxt_s;
      res_id_r    <= s1_id_r;
      res_valid_r <= s1_valid_r;
    end
  end

  assign res       = res_r;
  assign res_id    = res_id_r;
  assign res_valid = res_valid_r;
  assign busy      = s1_valid_r | res_valid_r;

endmodule

// File: tb/tb_add_arbiter.sv
// Self-checking bench for add_arbiter (N=7, NREQ=4): vector table plus
// reset-mid-operation sequence and a random scoreboarded run.
module tb_add_arbiter;

  logic        clk;
  logic        init;
  logic [3:0]  req;
  logic [31:0] lhs_flat;
  logic [31:0] rhs_flat;
  logic [3:0]  gnt;
  logic [7:0]  res;
  logic        res_valid;
  logic [1:0]  res_id;
  logic        busy;

  int n_pass;
  int n_total;

  add_arbiter #(.N(7), .NREQ(4), .IDW(2)) dut (
    .clk       (clk),
    .init      (init),
    .req       (req),
    .lhs_flat  (lhs_flat),
    .rhs_flat  (rhs_flat),
    .gnt       (gnt),
    .res       (res),
    .res_valid (res_valid),
    .res_id    (res_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] lhs;
    logic [31:0] rhs;
    logic [3:0]  gnt;
    logic        rv;
    logic [1:0]  id;
    logic [7:0]  res;
    logic        busy;
  } vec_t;

  typedef struct {
    int         due;
    logic [1:0] id;
    logic [7:0] s;
  } sb_t;

  vec_t vt[19];
  sb_t  q[$];

`ifdef ADD_ARB_SAT_EN
  localparam logic [7:0] OVF_RES = 8'd255;
`else
  localparam logic [7:0] OVF_RES = 8'd4;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [7:0] ref_sum(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
`ifdef ADD_ARB_SAT_EN
    return s[8] ? 8'hFF : s[7:0];
`else
    return s[7:0];
`endif
  endfunction

  initial begin
    logic [7:0] ol [4];
    logic [7:0] orr[4];
    logic [3:0] preq;
    int         wait_cnt[4];

    n_pass  = 0;
    n_total = 0;
    init     = 1'b1;
    req      = 4'b0000;
    lhs_flat = 32'h0;
    rhs_flat = 32'h0;

    // Operands packed {req3, req2, req1, req0}.
    vt[0]  = '{4'b1111, 32'h281E140A, 32'h04030201, 4'b0001, 1'b0, 2'd0, 8'd0,   1'b0};
    vt[1]  = '{4'b1111, 32'h281E140A, 32'h04030201, 4'b0010, 1'b0, 2'd0, 8'd0,   1'b1};
    vt[2]  = '{4'b1111, 32'h281E140A, 32'h04030201, 4'b0100, 1'b1, 2'd0, 8'd11,  1'b1};
    vt[3]  = '{4'b1111, 32'h281E140A, 32'h04030201, 4'b1000, 1'b1, 2'd1, 8'd22,  1'b1};
    vt[4]  = '{4'b0100, 32'h00030000, 32'h00010000, 4'b0100, 1'b1, 2'd2, 8'd33,  1'b1};
    vt[5]  = '{4'b0000, 32'h00000000, 32'h00000000, 4'b0000, 1'b1, 2'd3, 8'd44,  1'b1};
    vt[6]  = '{4'b0000, 32'h00000000, 32'h00000000, 4'b0000, 1'b1, 2'd2, 8'd4,   1'b1};
    vt[7]  = '{4'b0000, 32'h00000000, 32'h00000000, 4'b0000, 1'b0, 2'd0, 8'd0,   1'b0};
    vt[8]  = '{4'b0001, 32'h000000FA, 32'h0000000A, 4'b0001, 1'b0, 2'd0, 8'd0,   1'b0};
    vt[9]  = '{4'b0010, 32'h0000C800, 32'h00003700, 4'b0010, 1'b0, 2'd0, 8'd0,   1'b1};
    vt[10] = '{4'b0000, 32'h00000000, 32'h00000000, 4'b0000, 1'b1, 2'd0, OVF_RES, 1'b1};
    vt[11] = '{4'b0000, 32'h00000000, 32'h00000000, 4'b0000, 1'b1, 2'd1, 8'd255, 1'b1};
    vt[12] = '{4'b0000, 32'h00000000, 32'h00000000, 4'b0000, 1'b0, 2'd0, 8'd0,   1'b0};
    vt[13] = '{4'b1001, 32'h07000001, 32'h08000001, 4'b1000, 1'b0, 2'd0, 8'd0,   1'b0};
    vt[14] = '{4'b1001, 32'h07000001, 32'h08000001, 4'b0001, 1'b0, 2'd0, 8'd0,   1'b1};
    vt[15] = '{4'b1001, 32'h07000001, 32'h08000001, 4'b1000, 1'b1, 2'd3, 8'd15,  1'b1};
    vt[16] = '{4'b0000, 32'h00000000, 32'h00000000, 4'b0000, 1'b1, 2'd0, 8'd2,   1'b1};
    vt[17] = '{4'b0000, 32'h00000000, 32'h00000000, 4'b0000, 1'b1, 2'd3, 8'd15,  1'b1};
    vt[18] = '{4'b0000, 32'h00000000, 32'h00000000, 4'b0000, 1'b0, 2'd0, 8'd0,   1'b0};

    // Reset state with requests present.
    @(negedge clk);
    @(negedge clk);
    req = 4'b1111;
    #1;
    chk("rst_gnt",  32'(gnt),       32'h0);
    chk("rst_rv",   32'(res_valid), 32'h0);
    chk("rst_busy", 32'(busy),      32'h0);
    chk("rst_res",  32'(res),       32'h0);
    chk("rst_id",   32'(res_id),    32'h0);

    // Table: release reset together with the first vector.
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      init     = 1'b0;
      req      = vt[i].req;
      lhs_flat = vt[i].lhs;
      rhs_flat = vt[i].rhs;
      #1;
      chk($sformatf("v%0d_gnt", i),  32'(gnt),       32'(vt[i].gnt));
      chk($sformatf("v%0d_rv", i),   32'(res_valid), 32'(vt[i].rv));
      chk($sformatf("v%0d_busy", i), 32'(busy),      32'(vt[i].busy));
      if (vt[i].rv) begin
        chk($sformatf("v%0d_id", i),  32'(res_id), 32'(vt[i].id));
        chk($sformatf("v%0d_res", i), 32'(res),    32'(vt[i].res));
      end
    end

    // Reset in the cycle after a grant: the operation must vanish.
    @(negedge clk);
    req      = 4'b0010;
    lhs_flat = 32'h00000900;
    rhs_flat = 32'h00000900;
    #1;
    chk("mid_gnt", 32'(gnt), 32'b0010);
    @(negedge clk);
    init = 1'b1;
    req  = 4'b0000;
    #1;
    chk("mid_rv1",   32'(res_valid), 32'h0);
    chk("mid_busy",  32'(busy),      32'h0);
    chk("mid_res",   32'(res),       32'h0);
    chk("mid_id",    32'(res_id),    32'h0);
    @(negedge clk);
    req = 4'b1111;
    #1;
    chk("mid_rv2",   32'(res_valid), 32'h0);
    chk("mid_gnt0",  32'(gnt),       32'h0);
    @(negedge clk);
    init     = 1'b0;
    lhs_flat = 32'h00000005;
    rhs_flat = 32'h00000006;
    #1;
    chk("post_gnt",  32'(gnt),       32'b0001);
    chk("post_rv",   32'(res_valid), 32'h0);
    @(negedge clk);
    req = 4'b0000;
    #1;
    chk("post_rv1",  32'(res_valid), 32'h0);
    @(negedge clk);
    #1;
    chk("post_rv2",  32'(res_valid), 32'h1);
    chk("post_id",   32'(res_id),    32'h0);
    chk("post_res",  32'(res),       32'd11);
    @(negedge clk);
    #1;
    chk("post_rv3",  32'(res_valid), 32'h0);

    // Random traffic with hold-until-grant protocol and a result scoreboard.
    preq = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      ol[i] = 8'h0;
      orr[i] = 8'h0;
      wait_cnt[i] = 0;
    end
    for (int cyc = 0; cyc < 110; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (cyc < 100 && !preq[i] && $urandom_range(0, 2) != 0) begin
          preq[i] = 1'b1;
          ol[i]   = 8'($urandom);
          orr[i]  = 8'($urandom);
        end
      end
      req      = preq;
      lhs_flat = {ol[3], ol[2], ol[1], ol[0]};
      rhs_flat = {orr[3], orr[2], orr[1], orr[0]};
      #1;
      if (q.size() > 0 && q[0].due == cyc) begin
        chk("sb_rv",  32'(res_valid), 32'h1);
        chk("sb_id",  32'(res_id),    32'(q[0].id));
        chk("sb_res", 32'(res),       32'(q[0].s));
        void'(q.pop_front());
      end else begin
        chk("sb_idle_rv", 32'(res_valid), 32'h0);
      end
      chk("rnd_subset", 32'(gnt & ~req), 32'h0);
      chk("rnd_any",    32'(gnt != 4'b0000), 32'(req != 4'b0000));
      chk("rnd_onehot", 32'($countones(gnt) <= 1), 32'h1);
      for (int i = 0; i < 4; i++) begin
        if (gnt[i]) begin
          q.push_back('{cyc + 2, 2'(i), ref_sum(ol[i], orr[i])});
          preq[i]     = 1'b0;
          wait_cnt[i] = 0;
          for (int j = 0; j < 4; j++) begin
            if (j != i && preq[j]) begin
              wait_cnt[j]++;
              chk($sformatf("fair_%0d", j), 32'(wait_cnt[j] <= 3), 32'h1);
            end
          end
        end
      end
    end
    chk("sb_drained", 32'(q.size()), 32'h0);
    chk("idle_busy",  32'(busy),     32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
